// File: rtl/gpu_pkg.sv
// Shared types for the shape sequencer: shape/edge/state encodings and opcode geometry.
// Pure declarations, no logic.
package gpu_pkg;

    localparam int OPCODE_W = 74;
    localparam int LOC_W    = 19;
    localparam int COLOR_W  = 16;

    typedef enum logic [1:0] {
        SHAPE_LINE     = 2'd0,
        SHAPE_TRIANGLE = 2'd1,
        SHAPE_CIRCLE   = 2'd2
    } shape_t;

    typedef enum logic [3:0] {
        L1   = 4'd0,
        TRI1 = 4'd1,
        TRI2 = 4'd2,
        TRI3 = 4'd3,
        CIR1 = 4'd4
    } edge_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_t;

    function automatic edge_sel_t first_edge(input logic [1:0] shape);
        case (shape)
            SHAPE_TRIANGLE: first_edge = TRI1;
            SHAPE_CIRCLE:   first_edge = CIR1;
            default:        first_edge = L1;
        endcase
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle counter with synchronous clear and enable; tc pulses combinationally on the MAX-th enabled cycle.
// Latency: tc asserts in the cycle the count sits at MAX-1 with enable high.
// Backpressure: none; count holds at the terminal value until cleared.
module seq_watchdog #(
    parameter int MAX = 4096
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == CW'(MAX - 1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/shape_sequencer.sv
// Accepts one shape opcode, steps output_sel through its edges, pulsing draw_start and awaiting draw_done per edge.
// Latency: draw_start one cycle after accept; shape_done one cycle after the last draw_done; op_ready two after it.
// Backpressure: op_ready only in IDLE; SHAPE_SEQ_WATCHDOG_EN adds a WAIT timeout reported on err_timeout.
module shape_sequencer
    import gpu_pkg::*;
#(
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                op_valid,
    input  logic [1:0]          op_shape,
    input  logic [OPCODE_W-1:0] opdata,
    output logic                op_ready,
    output logic [OPCODE_W-1:0] opdata_q,
    output logic [3:0]          output_sel,
    output logic                draw_start,
    output logic                draw_circle,
    input  logic                draw_done,
    output logic                shape_done,
`ifdef SHAPE_SEQ_WATCHDOG_EN
    output logic                err_timeout,
`endif
    output logic                err_shape
);

    seq_state_t state;
    edge_sel_t  sel_q;

    assign op_ready   = (state == ST_IDLE);
    assign output_sel = sel_q;

`ifdef SHAPE_SEQ_WATCHDOG_EN
    logic wdog_tc;

    seq_watchdog #(.MAX(WDOG_CYCLES)) u_wdog (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (draw_start),
        .en    (state == ST_WAIT),
        .tc    (wdog_tc)
    );
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= ST_IDLE;
            sel_q       <= L1;
            opdata_q    <= '0;
            draw_start  <= 1'b0;
            draw_circle <= 1'b0;
            shape_done  <= 1'b0;
            err_shape   <= 1'b0;
`ifdef SHAPE_SEQ_WATCHDOG_EN
            err_timeout <= 1'b0;
`endif
        end else begin
            draw_start <= 1'b0;
            shape_done <= 1'b0;
            err_shape  <= 1'b0;
`ifdef SHAPE_SEQ_WATCHDOG_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        if (op_shape == 2'd3) begin
                            err_shape <= 1'b1;
                        end else begin
                            opdata_q    <= opdata;
                            sel_q       <= first_edge(op_shape);
                            draw_circle <= (op_shape == SHAPE_CIRCLE);
                            draw_start  <= 1'b1;
                            state       <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    // A done coinciding with the watchdog terminal count takes priority.
                    if (draw_done) begin
                        if (sel_q == TRI1 || sel_q == TRI2) begin
                            sel_q      <= edge_sel_t'(sel_q + 4'd1);
                            draw_start <= 1'b1;
                            state      <= ST_ISSUE;
                        end else begin
                            shape_done <= 1'b1;
                            state      <= ST_FINISH;
                        end
                    end
`ifdef SHAPE_SEQ_WATCHDOG_EN
                    else if (wdog_tc) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
`endif
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shape_sequencer.sv
// Scoreboard bench for shape_sequencer; watchdog cases compile in with SHAPE_SEQ_WATCHDOG_EN.
// Stimulus pushes expected output events; a negedge monitor pops and compares them.
module tb_shape_sequencer;

    localparam int K_START = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;
    localparam int K_TMO   = 3;

    typedef struct {
        int          kind;
        logic [3:0]  sel;
        logic        circ;
        logic [73:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_shape = 2'd0;
    logic [73:0] opdata = '0;
    logic        op_ready;
    logic [73:0] opdata_q;
    logic [3:0]  output_sel;
    logic        draw_start;
    logic        draw_circle;
    logic        draw_done = 1'b0;
    logic        shape_done;
    logic        err_shape;
`ifdef SHAPE_SEQ_WATCHDOG_EN
    logic        err_timeout;
`endif

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    shape_sequencer #(.WDOG_CYCLES(8)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .op_valid    (op_valid),
        .op_shape    (op_shape),
        .opdata      (opdata),
        .op_ready    (op_ready),
        .opdata_q    (opdata_q),
        .output_sel  (output_sel),
        .draw_start  (draw_start),
        .draw_circle (draw_circle),
        .draw_done   (draw_done),
        .shape_done  (shape_done),
`ifdef SHAPE_SEQ_WATCHDOG_EN
        .err_timeout (err_timeout),
`endif
        .err_shape   (err_shape)
    );

    task automatic pop_check(input int kind);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d, expected none", kind);
        end else begin
            e = q.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL event_kind: got %0d, expected %0d", kind, e.kind);
            end else if (kind == K_START &&
                         (output_sel !== e.sel || draw_circle !== e.circ || opdata_q !== e.dat)) begin
                errors++;
                $display("FAIL start_fields: sel %0d circ %0b dat %h, expected sel %0d circ %0b dat %h",
                         output_sel, draw_circle, opdata_q, e.sel, e.circ, e.dat);
            end
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (draw_start) pop_check(K_START);
            if (shape_done) pop_check(K_DONE);
            if (err_shape)  pop_check(K_ERR);
`ifdef SHAPE_SEQ_WATCHDOG_EN
            if (err_timeout) pop_check(K_TMO);
`endif
        end
    end

    task automatic push(input int kind, input logic [3:0] sel, input logic circ, input logic [73:0] dat);
        exp_t e;
        e.kind = kind; e.sel = sel; e.circ = circ; e.dat = dat;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] shape, input logic [73:0] dat);
        int n = 0;
        while (!op_ready && n < 50) begin cyc(); n++; end
        if (!op_ready) begin
            checks++; errors++;
            $display("FAIL op_ready_wait: got 0, expected 1 within 50 cycles");
        end
        op_valid = 1'b1; op_shape = shape; opdata = dat;
        cyc();
        op_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!draw_start && n < 20) begin cyc(); n++; end
        checks++;
        if (!draw_start) begin
            errors++;
            $display("FAIL draw_start_wait: got 0, expected 1 within 20 cycles");
        end
    endtask

    // Engine model: done pulse d cycles after the start cycle.
    task automatic done_after(input int d);
        repeat (d) cyc();
        draw_done = 1'b1;
        cyc();
        draw_done = 1'b0;
    endtask

    localparam logic [73:0] D1 = {16'h1234, 19'd5, 19'd9, 19'd0, 1'b0};
    localparam logic [73:0] D2 = {16'hBEEF, 19'd1, 19'd2, 19'd3, 1'b1};
    localparam logic [73:0] D3 = {16'hC1C1, 19'd100, 19'd7, 19'd0, 1'b1};
    localparam logic [73:0] D4 = {16'h0F0F, 19'd11, 19'd22, 19'd33, 1'b0};
    localparam logic [73:0] D5 = {16'hDEAD, 19'd4, 19'd4, 19'd4, 1'b1};
    localparam logic [73:0] D6 = {16'h5A5A, 19'd6, 19'd7, 19'd8, 1'b0};

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) cyc();
        n_rst = 1'b1;
        cyc();
        chk("rst_op_ready", 74'(op_ready), 74'(1));
        chk("rst_opdata_q", opdata_q, '0);
        chk("rst_output_sel", 74'(output_sel), 74'(0));
        chk("rst_pulses", 74'({draw_start, draw_circle, shape_done, err_shape}), 74'(0));

        // LINE
        push(K_START, 4'd0, 1'b0, D1);
        push(K_DONE, 4'd0, 1'b0, '0);
        send(2'd0, D1);
        wait_start();
        done_after(2);
        chk("line_busy", 74'(op_ready), 74'(0));
        chk("line_opdata_q", opdata_q, D1);
        cyc();
        chk("line_ready", 74'(op_ready), 74'(1));

        // TRIANGLE
        push(K_START, 4'd1, 1'b0, D2);
        push(K_START, 4'd2, 1'b0, D2);
        push(K_START, 4'd3, 1'b0, D2);
        push(K_DONE, 4'd0, 1'b0, '0);
        send(2'd1, D2);
        wait_start(); done_after(1);
        wait_start(); done_after(3);
        wait_start(); done_after(5);
        chk("tri_busy", 74'(op_ready), 74'(0));
        cyc();
        chk("tri_ready", 74'(op_ready), 74'(1));

        // CIRCLE with a second opcode held on the input throughout
        push(K_START, 4'd4, 1'b1, D3);
        push(K_DONE, 4'd0, 1'b0, '0);
        push(K_START, 4'd0, 1'b0, D4);
        push(K_DONE, 4'd0, 1'b0, '0);
        op_valid = 1'b1; op_shape = 2'd2; opdata = D3;
        cyc();
        op_shape = 2'd0; opdata = D4;
        done_after(1);
        chk("cir_busy", 74'(op_ready), 74'(0));
        chk("cir_opdata_stable", opdata_q, D3);
        chk("cir_sel", 74'({output_sel, draw_circle}), 74'({4'd4, 1'b1}));
        cyc();
        chk("cir_ready", 74'(op_ready), 74'(1));
        cyc();
        op_valid = 1'b0;
        chk("second_accept_start", 74'(draw_start), 74'(1));
        chk("second_opdata_q", opdata_q, D4);
        done_after(2);
        cyc(); cyc();

        // Illegal shape
        push(K_ERR, 4'd0, 1'b0, '0);
        send(2'd3, D5);
        chk("ill_ready", 74'(op_ready), 74'(1));
        chk("ill_no_load", opdata_q, D4);
        repeat (3) cyc();
        chk("ill_ready_later", 74'(op_ready), 74'(1));

        // Reset while a triangle waits on TRI2
        push(K_START, 4'd1, 1'b0, D6);
        push(K_START, 4'd2, 1'b0, D6);
        send(2'd1, D6);
        wait_start(); done_after(1);
        wait_start();
        cyc();
        chk("pre_rst_sel", 74'(output_sel), 74'(2));
        n_rst = 1'b0;
        cyc();
        chk("mid_rst_ready", 74'(op_ready), 74'(1));
        chk("mid_rst_opdata_q", opdata_q, '0);
        chk("mid_rst_sel", 74'(output_sel), 74'(0));
        chk("mid_rst_pulses", 74'({draw_start, draw_circle, shape_done, err_shape}), 74'(0));
        n_rst = 1'b1;
        repeat (2) cyc();

`ifdef SHAPE_SEQ_WATCHDOG_EN
        chk("rst_err_timeout", 74'(err_timeout), 74'(0));
        push(K_START, 4'd0, 1'b0, D1);
        push(K_TMO, 4'd0, 1'b0, '0);
        send(2'd0, D1);
        wait_start();
        repeat (8) cyc();
        chk("wd_before_tmo", 74'(err_timeout), 74'(0));
        cyc();
        chk("wd_tmo", 74'(err_timeout), 74'(1));
        chk("wd_idle", 74'(op_ready), 74'(1));
        cyc();

        push(K_START, 4'd0, 1'b0, D2);
        push(K_DONE, 4'd0, 1'b0, '0);
        send(2'd0, D2);
        wait_start();
        done_after(8);
        chk("wd_done_wins", 74'({shape_done, err_timeout}), 74'(2'b10));
        cyc();
        chk("wd_done_ready", 74'(op_ready), 74'(1));
`endif

        repeat (3) cyc();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
